// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: ID-stage issue control. It stalls the decoded
// instruction on hazards that forwarding cannot cover: load-use, reads or
// writes that collide with the in-flight MDU destination, and MDU structural
// conflicts. It drives the PC/IF-ID hold and the ID/EX bubble, and keeps a
// saturating count of stall cycles.
module hazard_stall_unit #(
  parameter int REGW    = 5,
  parameter int MDU_LAT = 4,
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            id_uses_rs,
  input  logic            id_uses_rt,
  input  logic [REGW-1:0] id_rd,
  input  logic            id_regwrite,
  input  logic            id_is_load,
  input  logic            id_is_mdu,
  input  logic            flush,
  output logic            stall,
  output logic            bubble,
  output logic            issue,
  output logic            mdu_busy,
  output logic            mdu_done,
  output logic [CNTW-1:0] stall_cnt
);

  localparam logic [REGW-1:0] ZERO_REG  = {REGW{1'b0}};
  localparam logic [3:0]      MDU_LAT_C = 4'(MDU_LAT);
  localparam logic [CNTW-1:0] CNT_MAX   = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE   = {{(CNTW-1){1'b0}}, 1'b1};

  // Load currently in EX (its data only exists after MEM)
  logic            ex_ld_v_r;
  logic [REGW-1:0] ex_ld_rd_r;
  // In-flight MDU operation
  logic [3:0]      mdu_cnt_r;
  logic [REGW-1:0] mdu_rd_r;
  logic            mdu_wr_r;
  logic [CNTW-1:0] stall_cnt_r;

  logic            mdu_busy_s;
  logic            ld_haz_s;
  logic            mdu_raw_s;
  logic            mdu_waw_s;
  logic            mdu_str_s;
  logic            stall_s;
  logic            bubble_s;
  logic            issue_s;

  // True when the ID instruction actually reads register reg_idx
  // (register 0 is hard-wired zero and never carries a dependency).
  function automatic logic src_hit(
    input logic [REGW-1:0] reg_idx,
    input logic [REGW-1:0] rs,
    input logic [REGW-1:0] rt,
    input logic            use_rs,
    input logic            use_rt
  );
    return (reg_idx != ZERO_REG) &&
           ((use_rs && (rs == reg_idx)) || (use_rt && (rt == reg_idx)));
  endfunction

  // Hazard detection and issue decision for the instruction sitting in ID
  always_comb begin
    mdu_busy_s = (mdu_cnt_r != 4'd0);
    ld_haz_s   = ex_ld_v_r & src_hit(ex_ld_rd_r, id_rs, id_rt, id_uses_rs, id_uses_rt);
    mdu_raw_s  = mdu_busy_s & mdu_wr_r & src_hit(mdu_rd_r, id_rs, id_rt, id_uses_rs, id_uses_rt);
    mdu_waw_s  = mdu_busy_s & mdu_wr_r & id_regwrite & (id_rd != ZERO_REG) & (id_rd == mdu_rd_r);
    mdu_str_s  = mdu_busy_s & id_is_mdu;
    // A redirect squashes ID outright, so it overrides any stall request.
    stall_s    = id_valid & ~flush & (ld_haz_s | mdu_raw_s | mdu_waw_s | mdu_str_s);
    bubble_s   = stall_s | flush;
    issue_s    = id_valid & ~flush & ~stall_s;
  end

  // Track a load entering EX so the very next instruction can be held once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_ld_v_r  <= 1'b0;
      ex_ld_rd_r <= ZERO_REG;
    end else begin
      ex_ld_v_r  <= issue_s & id_is_load & id_regwrite & (id_rd != ZERO_REG);
      ex_ld_rd_r <= id_rd;
    end
  end

  // MDU occupancy counter; a new op may start in the cycle the count is 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdu_cnt_r <= 4'd0;
      mdu_rd_r  <= ZERO_REG;
      mdu_wr_r  <= 1'b0;
    end else if (issue_s && id_is_mdu) begin
      mdu_cnt_r <= MDU_LAT_C;
      mdu_rd_r  <= id_rd;
      mdu_wr_r  <= id_regwrite;
    end else if (mdu_busy_s) begin
      mdu_cnt_r <= mdu_cnt_r - 4'd1;
    end else begin
      mdu_cnt_r <= mdu_cnt_r;
    end
  end

  // Saturating stall-cycle counter for performance measurement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNTW{1'b0}};
    end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall     = stall_s;
  assign bubble    = bubble_s;
  assign issue     = issue_s;
  assign mdu_busy  = mdu_busy_s;
  assign mdu_done  = (mdu_cnt_r == 4'd1) & mdu_wr_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Testbench for hazard_stall_unit. Reference model tracks, per register,
// the first cycle at which a reader may issue, plus the issue cycle of the
// last MDU operation; expected outputs are derived from those times.
module tb_hazard_stall_unit;
  localparam int REGW = 5;
  localparam int LAT  = 4;
  localparam int SLAT = 15;
  localparam int CNTW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_is_load, id_is_mdu, flush;
  logic [REGW-1:0] id_rs, id_rt, id_rd;
  logic            stall, bubble, issue, mdu_busy, mdu_done;
  logic [CNTW-1:0] stall_cnt;

  // second instance with a long MDU latency, used for counter saturation
  logic            s_valid = 1'b0, s_is_mdu = 1'b0, s_zero = 1'b0;
  logic [REGW-1:0] s_zreg = 5'd0;
  logic            s_stall, s_bubble, s_issue, s_busy, s_done;
  logic [CNTW-1:0] s_cnt;

  hazard_stall_unit #(.REGW(REGW), .MDU_LAT(LAT), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .id_is_mdu(id_is_mdu),
    .flush(flush), .stall(stall), .bubble(bubble), .issue(issue),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done), .stall_cnt(stall_cnt));

  hazard_stall_unit #(.REGW(REGW), .MDU_LAT(SLAT), .CNTW(CNTW)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(s_valid), .id_rs(s_zreg), .id_rt(s_zreg),
    .id_uses_rs(s_zero), .id_uses_rt(s_zero), .id_rd(s_zreg),
    .id_regwrite(s_zero), .id_is_load(s_zero), .id_is_mdu(s_is_mdu),
    .flush(s_zero), .stall(s_stall), .bubble(s_bubble), .issue(s_issue),
    .mdu_busy(s_busy), .mdu_done(s_done), .stall_cnt(s_cnt));

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int cyc;
  int ready[32];
  int mdu_iss;
  int mdu_rdm;
  bit mdu_wrm;
  int cnt_m;
  bit e_stall, e_bubble, e_issue, e_busy, e_done;
  logic [CNTW+4:0] exp_v, obs_v;

  task automatic clear_inputs();
    id_valid = 1'b0; id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_regwrite = 1'b0;
    id_is_load = 1'b0; id_is_mdu = 1'b0; flush = 1'b0;
    id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ready[i] = 0;
    mdu_iss = -100; mdu_rdm = 0; mdu_wrm = 1'b0; cnt_m = 0; cyc = 0;
  endtask

  function automatic void model_eval();
    bit busy, haz;
    busy = (cyc > mdu_iss) && (cyc <= mdu_iss + LAT);
    haz  = 1'b0;
    if (id_uses_rs && id_rs != 5'd0 && cyc < ready[id_rs]) haz = 1'b1;
    if (id_uses_rt && id_rt != 5'd0 && cyc < ready[id_rt]) haz = 1'b1;
    if (busy && mdu_wrm && id_regwrite && id_rd != 5'd0 && int'(id_rd) == mdu_rdm) haz = 1'b1;
    if (busy && id_is_mdu) haz = 1'b1;
    e_stall  = id_valid && !flush && haz;
    e_bubble = e_stall || flush;
    e_issue  = id_valid && !flush && !e_stall;
    e_busy   = busy;
    e_done   = mdu_wrm && (cyc == mdu_iss + LAT);
    exp_v    = {e_stall, e_bubble, e_issue, e_busy, e_done, 16'(cnt_m)};
  endfunction

  function automatic void model_update();
    if (e_issue) begin
      if (id_is_mdu) begin
        mdu_iss = cyc; mdu_rdm = int'(id_rd); mdu_wrm = id_regwrite;
        if (id_regwrite && id_rd != 5'd0) ready[id_rd] = cyc + LAT + 1;
      end else if (id_regwrite && id_rd != 5'd0) begin
        ready[id_rd] = id_is_load ? cyc + 2 : cyc + 1;
      end
    end
    if (e_stall && cnt_m < 65535) cnt_m = cnt_m + 1;
  endfunction

  // compute expectation for the current inputs and move to the sampling edge
  task automatic half();
    model_eval();
    @(negedge clk);
    obs_v = {stall, bubble, issue, mdu_busy, mdu_done, stall_cnt};
  endtask

  task automatic finish_cyc();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    s_valid = 1'b0; s_is_mdu = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic set_op(input bit ld, input bit mdu, input bit wr, input int rd,
                        input bit urs, input int rs, input bit urt, input int rt);
    id_valid = 1'b1; id_is_load = ld; id_is_mdu = mdu; id_regwrite = wr; id_rd = 5'(rd);
    id_uses_rs = urs; id_rs = 5'(rs); id_uses_rt = urt; id_rt = 5'(rt); flush = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #3;
    n_checks++;
    if ({stall, bubble, issue, mdu_busy, mdu_done, stall_cnt} !== 21'd0) begin
      n_fail++; $display("FAIL reset_async: got %h expected 0", {stall, bubble, issue, mdu_busy, mdu_done, stall_cnt});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    half();
    n_checks++;
    if (obs_v !== 21'd0) begin n_fail++; $display("FAIL reset_after: got %h expected 0", obs_v); end
    finish_cyc();
  endtask

  task automatic test_load_use();
    do_reset();
    set_op(1, 0, 1, 5, 1, 1, 0, 0);            // lw r5
    half();
    n_checks++;
    if (obs_v !== exp_v || issue !== 1'b1) begin n_fail++; $display("FAIL ld_issue: got %h expected %h", obs_v, exp_v); end
    finish_cyc();
    set_op(0, 0, 1, 6, 1, 5, 1, 7);            // add r6,r5,r7
    half();
    n_checks++;
    if (obs_v !== exp_v || {stall, bubble, issue} !== 3'b110) begin
      n_fail++; $display("FAIL ld_use_stall: got %h expected %h", obs_v, exp_v);
    end
    finish_cyc();
    half();
    n_checks++;
    if (obs_v !== exp_v || issue !== 1'b1 || stall_cnt !== 16'd1) begin
      n_fail++; $display("FAIL ld_use_release: got %h expected %h", obs_v, exp_v);
    end
    finish_cyc();
  endtask

  task automatic test_no_hazard();
    do_reset();
    set_op(1, 0, 1, 0, 0, 0, 0, 0);            // load to r0
    half(); finish_cyc();
    set_op(0, 0, 1, 4, 1, 0, 1, 0);            // reads r0
    half();
    n_checks++;
    if (obs_v !== exp_v || {stall, issue} !== 2'b01) begin n_fail++; $display("FAIL ld_r0: got %h expected %h", obs_v, exp_v); end
    finish_cyc();
    set_op(1, 0, 1, 5, 0, 0, 0, 0);            // lw r5
    half(); finish_cyc();
    set_op(0, 0, 1, 8, 0, 5, 1, 2);            // rs=5 but not used
    half();
    n_checks++;
    if (obs_v !== exp_v || {stall, issue} !== 2'b01) begin n_fail++; $display("FAIL ld_unused_rs: got %h expected %h", obs_v, exp_v); end
    finish_cyc();
  endtask

  task automatic test_mdu_raw();
    do_reset();
    set_op(0, 1, 1, 9, 1, 1, 1, 2);            // mul r9
    half(); finish_cyc();
    set_op(0, 0, 1, 10, 1, 9, 0, 0);           // reads r9
    for (int k = 1; k <= 5; k++) begin
      half();
      n_checks++;
      if (obs_v !== exp_v || mdu_busy !== (k <= 4) || mdu_done !== (k == 4) || issue !== (k == 5)) begin
        n_fail++; $display("FAIL mdu_raw_c%0d: got %h expected %h", k, obs_v, exp_v);
      end
      finish_cyc();
    end
    clear_inputs();
    half();
    n_checks++;
    if (stall_cnt !== 16'd4) begin n_fail++; $display("FAIL mdu_raw_cnt: got %0d expected 4", stall_cnt); end
    finish_cyc();
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_op(0, 1, 1, 9, 0, 0, 0, 0);
    half(); finish_cyc();
    set_op(0, 0, 1, 2, 1, 3, 1, 4);            // independent ALU op
    half();
    n_checks++;
    if (obs_v !== exp_v || {stall, issue, mdu_busy} !== 3'b011) begin n_fail++; $display("FAIL b2b_indep: got %h expected %h", obs_v, exp_v); end
    finish_cyc();
    set_op(0, 1, 1, 10, 0, 0, 0, 0);           // second MDU op
    for (int k = 2; k <= 6; k++) begin
      if (k == 6) clear_inputs();
      half();
      n_checks++;
      if (obs_v !== exp_v || issue !== (k == 5) || mdu_busy !== (k != 5)) begin
        n_fail++; $display("FAIL b2b_c%0d: got %h expected %h", k, obs_v, exp_v);
      end
      finish_cyc();
    end
  endtask

  task automatic test_waw_flush();
    do_reset();
    set_op(0, 1, 1, 3, 0, 0, 0, 0);
    half(); finish_cyc();
    set_op(0, 0, 1, 3, 1, 1, 0, 0);            // writes r3 (WAW)
    half();
    n_checks++;
    if (obs_v !== exp_v || stall !== 1'b1) begin n_fail++; $display("FAIL waw_stall: got %h expected %h", obs_v, exp_v); end
    finish_cyc();
    flush = 1'b1;
    half();
    n_checks++;
    if (obs_v !== exp_v || {stall, bubble, issue} !== 3'b010) begin n_fail++; $display("FAIL waw_flush: got %h expected %h", obs_v, exp_v); end
    finish_cyc();
    clear_inputs();
    for (int k = 3; k <= 5; k++) begin
      half();
      n_checks++;
      if (obs_v !== exp_v || mdu_done !== (k == 4)) begin n_fail++; $display("FAIL flush_mdu_c%0d: got %h expected %h", k, obs_v, exp_v); end
      finish_cyc();
    end
  endtask

  task automatic test_rst_mid_mdu();
    do_reset();
    set_op(0, 1, 1, 9, 0, 0, 0, 0);
    half(); finish_cyc();
    set_op(0, 0, 0, 0, 1, 9, 0, 0);
    half(); finish_cyc();
    half(); finish_cyc();
    half();
    n_checks++;
    if (obs_v !== exp_v || {mdu_busy, stall_cnt} !== {1'b1, 16'd2}) begin n_fail++; $display("FAIL pre_rst: got %h expected %h", obs_v, exp_v); end
    #2;
    id_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({mdu_busy, mdu_done, stall_cnt, stall, issue} !== 20'd0) begin
      n_fail++; $display("FAIL rst_mid: got busy=%b done=%b cnt=%0d expected 0", mdu_busy, mdu_done, stall_cnt);
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({mdu_busy, mdu_done} !== 2'b00) begin n_fail++; $display("FAIL rst_no_done%0d: got %b expected 00", k, {mdu_busy, mdu_done}); end
    end
    rst = 1'b0;
    model_reset();
    clear_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      id_valid    = ($urandom_range(0, 9) != 0);
      id_rs       = 5'($urandom_range(0, 6));
      id_rt       = 5'($urandom_range(0, 6));
      id_rd       = 5'($urandom_range(0, 6));
      id_uses_rs  = 1'($urandom_range(0, 1));
      id_uses_rt  = 1'($urandom_range(0, 1));
      id_regwrite = ($urandom_range(0, 9) < 7);
      id_is_load  = ($urandom_range(0, 9) < 3);
      id_is_mdu   = ($urandom_range(0, 9) < 2);
      flush       = ($urandom_range(0, 9) == 0);
      half();
      n_checks++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL random_c%0d: got %h expected %h", k, obs_v, exp_v); end
      finish_cyc();
    end
    clear_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    s_valid = 1'b1; s_is_mdu = 1'b1;           // MDU ops back to back: 15 of every 16 cycles stall
    repeat (1600) @(posedge clk);
    #1;
    n_checks++;
    if (s_cnt !== 16'd1500) begin n_fail++; $display("FAIL sat_partial: got %0d expected 1500", s_cnt); end
    repeat (69920 - 1600) @(posedge clk);
    #1;
    n_checks++;
    if (s_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_full: got %h expected ffff", s_cnt); end
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (s_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h expected ffff", s_cnt); end
    s_valid = 1'b0; s_is_mdu = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_mdu_raw();
    test_back_to_back();
    test_waw_flush();
    test_rst_mid_mdu();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
